ps2_cmd_scheduler: RTL and testbench

//  Shares the single PS/2 host->device transmit path between two command requesters:

---
 rtl/ps2_cmd_pkg.sv | 21 ++
 rtl/ps2_ack_timer.sv | 40 ++++
 rtl/ps2_cmd_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ps2_cmd_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_cmd_pkg.sv
// Shared constants and FSM encoding for the PS/2 command scheduler.
package ps2_cmd_pkg;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERROR  = 8'hFC;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_TX  = 2'd2,
        WAIT_ACK = 2'd3
    } state_e;

    // Bytes that answer a command (consumed while waiting for a reply).
    function automatic logic is_reply(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERROR);
    endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Reply timeout counter: cleared per attempt, runs only while a reply is awaited.
module ps2_ack_timer
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned TO_W  = 22,
    parameter int unsigned LIMIT = 2_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the LIMIT-th enabled cycle after a clear.
    assign expire = en && (cnt_q == TO_W'(LIMIT - 1));

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Two-requester PS/2 command scheduler: arbitrates, sends, waits for ACK,
// retries on RESEND/timeout and forwards all other received bytes.
module ps2_cmd_scheduler
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 2_500_000,
    parameter int unsigned TO_W        = 22,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       owner,
    output logic       active,
    output logic       tx_write,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_read,
    input  logic [7:0] rx_data,
    output logic       strm_valid,
    output logic [7:0] strm_data
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          ptr_q, ptr_d;
    logic          hold_q, hold_d;
    logic          active_q, active_d;
    logic          tx_write_q, tx_write_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          strm_valid_q, strm_valid_d;
    logic [7:0]    strm_data_q, strm_data_d;
    logic [RW-1:0] retry_q, retry_d;

    logic hold_ok;
    logic winner;
    logic timer_expire;
    logic turnaround;

    // Locked owner keeps the grant only while it still holds both lock and req.
    assign hold_ok    = hold_q && lock[owner_q] && req[owner_q];
    assign winner     = hold_ok ? owner_q : (req[ptr_q] ? ptr_q : ~ptr_q);
    // Requesters drop req on seeing done/err, so skip granting in that cycle.
    assign turnaround = (done_q != 2'b00) || (err_q != 2'b00);

    ps2_ack_timer #(
        .TO_W  (TO_W),
        .LIMIT (ACK_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == SEND),
        .en      (state_q == WAIT_ACK),
        .expire  (timer_expire)
    );

    // Arbitration, command sequencing and stream forwarding (next-state logic).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        active_d     = active_q;
        tx_write_d   = 1'b0;
        tx_data_d    = tx_data_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        strm_valid_d = 1'b0;
        strm_data_d  = strm_data_q;
        retry_d      = retry_q;

        case (state_q)
            IDLE: begin
                if (!hold_ok) begin
                    hold_d = 1'b0;
                end
                if ((req != 2'b00) && !tx_busy && !turnaround) begin
                    owner_d    = winner;
                    ptr_d      = ~winner;
                    tx_data_d  = winner ? cmd1 : cmd0;
                    retry_d    = '0;
                    active_d   = 1'b1;
                    tx_write_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                if (!tx_busy) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rx_read && (rx_data == PS2_ACK)) begin
                    done_d[owner_q] = 1'b1;
                    active_d        = 1'b0;
                    hold_d          = 1'b1;
                    state_d         = IDLE;
                end else if (rx_read && (rx_data == PS2_ERROR)) begin
                    err_d[owner_q] = 1'b1;
                    active_d       = 1'b0;
                    hold_d         = 1'b0;
                    state_d        = IDLE;
                end else if ((rx_read && (rx_data == PS2_RESEND)) || timer_expire) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d    = retry_q + 1'b1;
                        tx_data_d  = owner_q ? cmd1 : cmd0;
                        tx_write_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        err_d[owner_q] = 1'b1;
                        active_d       = 1'b0;
                        hold_d         = 1'b0;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_read && !((state_q == WAIT_ACK) && is_reply(rx_data))) begin
            strm_valid_d = 1'b1;
            strm_data_d  = rx_data;
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            ptr_q        <= 1'b0;
            hold_q       <= 1'b0;
            active_q     <= 1'b0;
            tx_write_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            strm_valid_q <= 1'b0;
            strm_data_q  <= 8'h00;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            active_q     <= active_d;
            tx_write_q   <= tx_write_d;
            tx_data_q    <= tx_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
            strm_valid_q <= strm_valid_d;
            strm_data_q  <= strm_data_d;
            retry_q      <= retry_d;
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign owner      = owner_q;
    assign active     = active_q;
    assign tx_write   = tx_write_q;
    assign tx_data    = tx_data_q;
    assign strm_valid = strm_valid_q;
    assign strm_data  = strm_data_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Scoreboard bench: a round-level model predicts service order, sends per
// attempt and outcomes; a monitor pops expectations as the DUT emits them.
module tb_ps2_cmd_scheduler;
    import ps2_cmd_pkg::*;

    localparam int unsigned A  = 40;
    localparam int unsigned MR = 2;
    localparam int R_ACK = 0, R_RESEND = 1, R_ERROR = 2, R_NONE = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] lock = 2'b00;
    logic [7:0] cmd0 = 8'h00;
    logic [7:0] cmd1 = 8'h00;
    logic [1:0] done, err;
    logic       owner, active, tx_write;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       strm_valid;
    logic [7:0] strm_data;

    typedef struct packed { logic port; logic is_err; } resp_t;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_strm[$];
    logic [7:0] inj_q[$];
    logic [7:0] grp0[$];
    logic [7:0] grp1[$];
    resp_t      exp_resp[$];
    int         dev_q[$];
    int         frc_q[$];

    int n_chk = 0, n_err = 0, cyc = 0, ptr_m = 0;
    bit to_pend = 0, ack_pend = 0, first_pend = 0;
    int to_start = 0, ack_cyc = 0, first_cyc = 0;
    resp_t mon_r;

    ps2_cmd_scheduler #(.ACK_TIMEOUT(A), .TO_W(6), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .cmd0(cmd0), .cmd1(cmd1),
        .done(done), .err(err), .owner(owner), .active(active),
        .tx_write(tx_write), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_read(rx_read), .rx_data(rx_data), .strm_valid(strm_valid), .strm_data(strm_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] resp_vec(input resp_t r);
        logic [3:0] v;
        v = 4'b0000;
        if (r.is_err) v[r.port] = 1'b1;
        else          v[2 + r.port] = 1'b1;
        return v;
    endfunction

    // Monitor: compare every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_write) begin
                if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_data", tx_data, exp_tx.pop_front());
                if (first_pend) begin check("grant_latency", cyc - first_cyc, 1); first_pend = 0; end
                if (to_pend) begin check("timeout_cycles", cyc - to_start, A + 1); to_pend = 0; end
            end
            if ((done | err) != 2'b00) begin
                if (exp_resp.size() == 0) check("resp_unexpected", {done, err}, 0);
                else begin
                    mon_r = exp_resp.pop_front();
                    check("resp_owner_active_done_err", {owner, active, done, err},
                          {mon_r.port, 1'b0, resp_vec(mon_r)});
                end
                if (ack_pend && done != 2'b00) begin check("done_latency", cyc - ack_cyc, 1); ack_pend = 0; end
                if (to_pend && err != 2'b00) begin check("timeout_err_cycles", cyc - to_start, A + 1); to_pend = 0; end
            end
            if (strm_valid) begin
                if (exp_strm.size() == 0) check("strm_unexpected", {24'h0, strm_data}, 32'hFFFF_FFFF);
                else check("strm_data", strm_data, exp_strm.pop_front());
            end
        end
    end

    // Device model: transmitter busy, then junk bytes and the scripted reply.
    initial begin : device
        int r;
        @(negedge clk);
        forever begin
            if (reset_n && tx_write) begin
                r = (dev_q.size() != 0) ? dev_q.pop_front() : R_NONE;
                tx_busy = 1'b1;
                repeat ($urandom_range(3, 8)) @(negedge clk);
                tx_busy = 1'b0;
                if (r == R_NONE) begin
                    to_pend = 1; to_start = cyc;
                end else begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    if ($urandom_range(0, 3) == 0) begin
                        rx_data = 8'($urandom_range(0, 8'hEF));
                        rx_read = 1'b1;
                        exp_strm.push_back(rx_data);
                        @(negedge clk); rx_read = 1'b0;
                        @(negedge clk);
                    end
                    rx_data = (r == R_ACK) ? PS2_ACK : (r == R_RESEND) ? PS2_RESEND : PS2_ERROR;
                    rx_read = 1'b1;
                    if (r == R_ACK) begin ack_pend = 1; ack_cyc = cyc; end
                    @(negedge clk); rx_read = 1'b0;
                end
            end else if (reset_n && inj_q.size() != 0) begin
                rx_data = inj_q.pop_front();
                rx_read = 1'b1;
                @(negedge clk); rx_read = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
    end

    function automatic int pick_reply();
        int x;
        x = $urandom_range(0, 99);
        if (x < 60) return R_ACK;
        if (x < 75) return R_RESEND;
        if (x < 88) return R_ERROR;
        return R_NONE;
    endfunction

    // One round: both ports raise req together with their byte groups.
    task automatic run_round();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] g[$];
        resp_t rr;
        int first, last, p, rep, n;
        bit ok;
        q0 = grp0; q1 = grp1;
        if (ptr_m == 0) first = (q0.size() != 0) ? 0 : 1;
        else            first = (q1.size() != 0) ? 1 : 0;
        last = first;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : 1 - first;
            if (p == 1) g = q1; else g = q0;
            if (g.size() != 0) begin
                last = p;
                for (int j = 0; j < g.size(); j++) begin
                    ok = 0;
                    for (int a = 0; a <= int'(MR); a++) begin
                        rep = (frc_q.size() != 0) ? frc_q.pop_front() : pick_reply();
                        dev_q.push_back(rep);
                        exp_tx.push_back(g[j]);
                        if (rep == R_ACK) begin ok = 1; break; end
                        if (rep == R_ERROR) break;
                    end
                    rr.port = (p == 1); rr.is_err = !ok;
                    exp_resp.push_back(rr);
                    if (!ok) break;
                end
            end
        end
        ptr_m = 1 - last;

        @(negedge clk);
        if (q0.size() != 0) cmd0 = q0[0];
        if (q1.size() != 0) cmd1 = q1[0];
        lock = {q1.size() > 1, q0.size() > 1};
        req  = {q1.size() != 0, q0.size() != 0};
        first_pend = 1; first_cyc = cyc;
        n = 0;
        while (req != 2'b00 && n < 3000) begin
            @(negedge clk); n++;
            if (done[0]) begin
                void'(q0.pop_front());
                if (q0.size() == 0) begin req[0] = 0; lock[0] = 0; end else cmd0 = q0[0];
            end
            if (err[0]) begin q0.delete(); req[0] = 0; lock[0] = 0; end
            if (done[1]) begin
                void'(q1.pop_front());
                if (q1.size() == 0) begin req[1] = 0; lock[1] = 0; end else cmd1 = q1[0];
            end
            if (err[1]) begin q1.delete(); req[1] = 0; lock[1] = 0; end
        end
        if (req != 2'b00) begin
            n_chk++; n_err++;
            $display("FAIL round_budget: req %b still pending after %0d cycles, expected all served", req, n);
            req = 2'b00; lock = 2'b00;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", {done, err, owner, active, tx_write, tx_data, strm_valid, strm_data}, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Contention twice: port 0 first both times.
        grp0 = '{8'hF4}; grp1 = '{8'hF5}; frc_q = '{R_ACK, R_ACK}; run_round();
        grp0 = '{8'hE6}; grp1 = '{8'hE8}; frc_q = '{R_ACK, R_ACK}; run_round();
        // Locked F3,C8 back-to-back while port 1 waits.
        grp0 = '{8'hF3, 8'hC8}; grp1 = '{8'hF2}; frc_q = '{R_ACK, R_ACK, R_ACK}; run_round();
        // Single command.
        grp0 = '{8'hF4}; grp1 = {}; frc_q = '{R_ACK}; run_round();
        // Resend twice then ACK; resend exhausted; timeouts; device error.
        grp0 = '{8'hF4}; frc_q = '{R_RESEND, R_RESEND, R_ACK}; run_round();
        grp0 = '{8'hE8}; frc_q = '{R_RESEND, R_RESEND, R_RESEND}; run_round();
        grp0 = '{8'hF2}; frc_q = '{R_NONE, R_NONE, R_NONE}; run_round();
        grp0 = '{8'hFF}; frc_q = '{R_ERROR}; run_round();

        // Stream in IDLE, including reply codes that must pass through.
        inj_q    = '{8'h08, 8'h01, 8'h02, 8'h00, PS2_BAT_OK, PS2_ACK, PS2_RESEND};
        exp_strm = '{8'h08, 8'h01, 8'h02, 8'h00, PS2_BAT_OK, PS2_ACK, PS2_RESEND};
        repeat (25) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            int s0, s1;
            s0 = $urandom_range(0, 3); s1 = $urandom_range(0, 3);
            if (s0 == 0 && s1 == 0) s0 = 1;
            grp0 = {}; grp1 = {}; frc_q = {};
            for (int j = 0; j < s0; j++) grp0.push_back(8'($urandom));
            for (int j = 0; j < s1; j++) grp1.push_back(8'($urandom));
            run_round();
        end

        // Reset while waiting for a reply.
        @(negedge clk);
        dev_q = '{R_NONE, R_NONE, R_NONE};
        exp_tx.push_back(8'h5A);
        cmd0 = 8'h5A; req = 2'b01; first_pend = 1; first_cyc = cyc;
        repeat (20) @(negedge clk);
        check("active_before_reset", active, 1);
        #2 reset_n = 1'b0;
        #1 check("reset_async_outputs", {done, err, owner, active, tx_write, tx_data, strm_valid, strm_data}, 0);
        req = 2'b00;
        exp_tx.delete(); exp_resp.delete(); dev_q.delete();
        to_pend = 0; ack_pend = 0; first_pend = 0; ptr_m = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (A + 20) @(negedge clk);
        check("post_reset_idle", {done, err, active, tx_write}, 0);

        for (int i = 0; i < 4; i++) begin
            grp0 = '{8'($urandom)}; grp1 = '{8'($urandom)}; frc_q = {};
            run_round();
        end

        repeat (10) @(negedge clk);
        check("exp_tx_left", exp_tx.size(), 0);
        check("exp_resp_left", exp_resp.size(), 0);
        check("exp_strm_left", exp_strm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
